// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: locks to a Fibonacci LFSR stream, then
// flywheels its own reference and counts bit errors with loss-of-lock detection.
module prbs_checker #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] TAPS        = 16'hD008,
  parameter int               LOCK_COUNT  = 16,
  parameter int               WINDOW      = 64,
  parameter int               LOSS_THRESH = 8,
  parameter int               ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_errors,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WBITS_W = $clog2(WINDOW + 1);
  localparam int WERRS_W = $clog2(LOSS_THRESH + 1);

  localparam logic [MATCH_W-1:0] LAST_MATCH = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WBITS_W-1:0] LAST_BIT   = WBITS_W'(WINDOW - 1);
  localparam logic [WERRS_W-1:0] LAST_ERR   = WERRS_W'(LOSS_THRESH - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t             state;
  logic [WIDTH-1:0]   hist;
  logic [MATCH_W-1:0] match_cnt;
  logic [WBITS_W-1:0] win_bits;
  logic [WERRS_W-1:0] win_errs;

  logic pred;
  logic mismatch;
  logic match_hit;
  logic count_err;

  assign pred      = ^(hist & TAPS);
  assign mismatch  = in_bit ^ pred;
  // An all-zero history predicts 0 forever, so it must never count as a match.
  assign match_hit = !mismatch && (hist != '0);
  assign count_err = in_valid && (state == LOCKED) && mismatch;

  // NOTE: every register below uses non-blocking assignment so all updates
  // see the pre-edge values of hist, state and the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      hist      <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state)
          SEARCH: begin
            hist <= {hist[WIDTH-2:0], in_bit};
            if (match_hit) begin
              if (match_cnt == LAST_MATCH) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                win_bits  <= '0;
                win_errs  <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Flywheel on the prediction so a line error cannot enter the taps.
            hist      <= {hist[WIDTH-2:0], pred};
            err_pulse <= mismatch;
            if (mismatch && win_errs == LAST_ERR) begin
              state     <= SEARCH;
              locked    <= 1'b0;
              match_cnt <= '0;
            end else if (win_bits == LAST_BIT) begin
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              win_bits <= win_bits + 1'b1;
              if (mismatch) win_errs <= win_errs + 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end

      // Clear wins over a coincident error; the pulse above still fires.
      if (clear_errors) begin
        err_count <= '0;
      end else if (count_err && err_count != '1) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: spec-level reference model, vector
// table and hand-built lock/loss/saturation sequences on two counter widths.
module tb_prbs_checker;

  localparam int              W       = 16;
  localparam logic [W-1:0]    TAPS_TB = 16'hD008;
  localparam int              LOCK_N  = 16;
  localparam int              WIN_N   = 64;
  localparam int              LOSS_N  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_bit;
  logic        clear_errors;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked3, err_pulse3;
  logic [2:0]  err_count3;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .clear_errors(clear_errors), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count)
  );

  prbs_checker #(.ERR_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .clear_errors(clear_errors), .locked(locked3), .err_pulse(err_pulse3),
    .err_count(err_count3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transmitter: x^16+x^15+x^13+x^4+1 Fibonacci LFSR, newest bit in g[0].
  logic [15:0] g;
  task automatic gen_next(output bit b);
    b = g[15] ^ g[14] ^ g[12] ^ g[3];
    g = {g[14:0], b};
  endtask

  // Reference model: history kept as a queue of reference bits, newest last.
  bit mq[$];
  bit m_locked, m_pulse;
  int m_match, m_winb, m_wine, m_cnt, m_cnt3;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < W; i++) mq.push_back(1'b0);
    m_locked = 0; m_pulse = 0;
    m_match = 0; m_winb = 0; m_wine = 0; m_cnt = 0; m_cnt3 = 0;
  endtask

  function automatic bit model_pred();
    bit p = 0;
    for (int i = 0; i < W; i++)
      if (TAPS_TB[i]) p ^= mq[mq.size() - 1 - i];
    return p;
  endfunction

  function automatic bit model_hist_nonzero();
    foreach (mq[i]) if (mq[i]) return 1;
    return 0;
  endfunction

  task automatic model_step(input bit v, input bit b, input bit clr);
    bit p, nz;
    m_pulse = 0;
    if (v) begin
      p  = model_pred();
      nz = model_hist_nonzero();
      void'(mq.pop_front());
      if (!m_locked) begin
        mq.push_back(b);
        if (b == p && nz) begin
          m_match++;
          if (m_match == LOCK_N) begin
            m_locked = 1; m_match = 0; m_winb = 0; m_wine = 0;
          end
        end else begin
          m_match = 0;
        end
      end else begin
        mq.push_back(p);
        m_winb++;
        if (b != p) begin
          m_pulse = 1;
          m_wine++;
          m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
          m_cnt3 = (m_cnt3 < 7)     ? m_cnt3 + 1 : m_cnt3;
        end
        if (b != p && m_wine == LOSS_N) begin
          m_locked = 0; m_match = 0;
        end else if (m_winb == WIN_N) begin
          m_winb = 0; m_wine = 0;
        end
      end
    end
    if (clr) begin
      m_cnt = 0; m_cnt3 = 0;
    end
  endtask

  // One clock: drive at the falling edge, compare 1 time unit after the rising edge.
  task automatic step_raw(input bit v, input bit b, input bit clr);
    @(negedge clk);
    in_valid = v; in_bit = b; clear_errors = clr;
    @(posedge clk);
    model_step(v, b, clr);
    #1;
    check("model_locked",     locked,     m_locked);
    check("model_err_pulse",  err_pulse,  m_pulse);
    check("model_err_count",  err_count,  m_cnt);
    check("model_locked3",    locked3,    m_locked);
    check("model_err_count3", err_count3, m_cnt3);
  endtask

  task automatic step(input bit v, input bit flip, input bit clr);
    bit b;
    if (v) begin
      gen_next(b);
      b ^= flip;
    end else begin
      b = 1'($urandom);
    end
    step_raw(v, b, clr);
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst_n = 0; in_valid = 0; in_bit = 0; clear_errors = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  typedef struct {
    bit v; bit f; bit c;
    bit e_locked; bit e_pulse; int e_count;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0]  = '{1, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 1, 1};
    tbl[2]  = '{1, 0, 0, 1, 0, 1};
    tbl[3]  = '{0, 0, 0, 1, 0, 1};
    tbl[4]  = '{1, 1, 0, 1, 1, 2};
    tbl[5]  = '{0, 0, 0, 1, 0, 2};
    tbl[6]  = '{1, 0, 0, 1, 0, 2};
    tbl[7]  = '{1, 1, 1, 1, 1, 0};
    tbl[8]  = '{1, 0, 0, 1, 0, 0};
    tbl[9]  = '{0, 1, 0, 1, 0, 0};
    tbl[10] = '{1, 0, 1, 1, 0, 0};
    tbl[11] = '{1, 1, 0, 1, 1, 1};

    rst_n = 0; in_valid = 0; in_bit = 0; clear_errors = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Acquisition from the reference seed.
    g = 16'hACE1;
    for (int i = 0; i < W + LOCK_N; i++) step(1, 0, 0);
    check("lock_by_bit_32", locked, 1);
    for (int i = 0; i < 1000; i++) step(1, 0, 0);
    check("clean_err_count", err_count, 0);

    // Single errors, gated valid and clear-vs-error priority.
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].f, tbl[i].c);
      check($sformatf("tbl%0d_locked", i), locked, tbl[i].e_locked);
      check($sformatf("tbl%0d_pulse", i), err_pulse, tbl[i].e_pulse);
      check($sformatf("tbl%0d_count", i), err_count, tbl[i].e_count);
    end

    // Asynchronous reset between clock edges while locked with errors counted.
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    check("async_rst_locked", locked, 0);
    check("async_rst_pulse", err_pulse, 0);
    check("async_rst_count", err_count, 0);
    check("async_rst_count3", err_count3, 0);
    model_reset();
    @(negedge clk);
    in_valid = 0; clear_errors = 0;
    rst_n = 1;
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    check("idle_after_rst_locked", locked, 0);
    check("idle_after_rst_count", err_count, 0);

    // Loss of lock: 8 errors right at the start of a fresh window.
    n = 0;
    while (!locked && n < 40) begin step(1, 0, 0); n++; end
    check("acquire_after_rst", locked, 1);
    for (int i = 1; i <= LOSS_N; i++) begin
      step(1, 1, 0);
      check($sformatf("loss_err%0d_locked", i), locked, (i < LOSS_N) ? 1 : 0);
    end
    check("loss_err_count", err_count, 8);
    check("loss_err_count3_sat", err_count3, 7);
    n = 0;
    while (!locked && n < W + LOCK_N) begin step(1, 0, 0); n++; end
    check("relock_within_32", locked, 1);

    // 7 errors in each of 4 windows: no loss; narrow counter stays saturated.
    for (int k = 0; k < 4 * WIN_N; k++) step(1, (k % WIN_N) < 7, 0);
    check("seven_per_window_locked", locked, 1);
    check("seven_per_window_count", err_count, 36);
    check("seven_per_window_count3", err_count3, 7);
    step(1, 1, 1);
    check("clear_coincident_pulse", err_pulse, 1);
    check("clear_coincident_count", err_count, 0);
    check("clear_coincident_count3", err_count3, 0);

    // Degenerate streams must never lock.
    sync_reset();
    for (int i = 0; i < 500; i++) step_raw(1, 0, 0);
    check("all_zero_no_lock", locked, 0);
    sync_reset();
    for (int i = 0; i < 500; i++) step_raw(1, 1, 0);
    check("all_ones_no_lock", locked, 0);

    // Randomized traffic against the model.
    sync_reset();
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(3) != 0), ($urandom_range(59) == 0), ($urandom_range(199) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
